// File: rtl/window_scan_scheduler_pkg.sv
// Shared window-buffer definitions: scheduler state encoding and default geometry.
package window_scan_scheduler_pkg;

  localparam int unsigned DEF_IMG_W = 640;
  localparam int unsigned DEF_IMG_H = 480;
  localparam int unsigned DEF_K     = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/window_scan_scheduler_pixel_position_counter.sv
// Row/column position of the next pixel, with wrap at frame edges and terminal flags.
module pixel_position_counter
  import window_scan_scheduler_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     advance,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     col_last_c,
  output logic                     row_last_c
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  assign col_last_c = (col == CW'(IMG_W - 1));
  assign row_last_c = (row == RW'(IMG_H - 1));

  // Last pixel of the frame wraps both counters back to the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_last_c) begin
        col <= '0;
        row <= row_last_c ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/window_scan_scheduler.sv
// Raster-scan scheduler for a KxK sliding window: pixel handshake, fill/run sequencing
// and a per-pixel window-valid strobe.
module window_scan_scheduler
  import window_scan_scheduler_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned K     = DEF_K
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     pixel_valid_i,
  output logic                     pixel_ready_o,
  output logic                     lb_wr_en_o,
  output logic                     win_valid_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic                     busy_o,
  output logic                     frame_done_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  state_t        state_q;
  state_t        state_d;
  logic          ready_q;
  logic          ready_d;
  logic          win_valid_q;
  logic          win_valid_d;
  logic          done_q;
  logic          done_d;
  logic          accept_c;
  logic          col_last_c;
  logic          row_last_c;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Abort outranks a same-cycle handshake so no pixel slips into the line buffer.
  assign accept_c = pixel_valid_i & ready_q & ~abort_i;

  pixel_position_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .clear      (abort_i),
    .advance    (accept_c),
    .col        (col),
    .row        (row),
    .col_last_c (col_last_c),
    .row_last_c (row_last_c)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_FILL;
      ST_FILL: if (accept_c && col_last_c && (row == RW'(K - 2))) state_d = ST_RUN;
      ST_RUN:  if (accept_c && col_last_c && row_last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) state_d = ST_IDLE;

    win_valid_d = accept_c && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
    ready_d     = (state_d == ST_FILL) || (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      win_valid_q <= win_valid_d;
      done_q      <= done_d;
    end
  end

  assign pixel_ready_o = ready_q;
  assign busy_o        = ready_q;
  assign lb_wr_en_o    = accept_c;
  assign win_valid_o   = win_valid_q;
  assign frame_done_o  = done_q;
  assign col_o         = col;
  assign row_o         = row;

endmodule
